alu_issue_stage: RTL

// - Producer side of the ALU operand/operation interface. Decodes RV32I opcode/funct3/funct7 into the
//   4-bit ALU Operation code and selects the SrcA/SrcB operands.
// - Registers the result behind a valid/ready handshake with a 2-entry skid buffer.
// - Sits between register-read and the combinational ALU; out_* drives ALU SrcA/SrcB/Operation directly.

---
 rtl/alu_issue_stage.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
// Producer side of the ALU operand/operation interface. Decodes RV32I
// opcode/funct3/funct7 into a 4-bit ALU Operation code, selects SrcA/SrcB,
// and registers the request behind a valid/ready handshake using an output
// register plus one skid register (strict FIFO, no drop, no duplication).
//
// Optional feature macro: ALU_ISSUE_CNT_EN
//   When defined, adds cnt_issued[15:0] and cnt_illegal[15:0], which count
//   output transfers and illegal output transfers (wrapping, flush-immune).

module alu_issue_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [6:0]               in_opcode,
    input  logic [2:0]               in_funct3,
    input  logic [6:0]               in_funct7,
    input  logic [DATA_WIDTH-1:0]    in_rs1,
    input  logic [DATA_WIDTH-1:0]    in_rs2,
    input  logic [DATA_WIDTH-1:0]    in_imm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_LENGTH-1:0] out_op,
    output logic [DATA_WIDTH-1:0]    out_src_a,
    output logic [DATA_WIDTH-1:0]    out_src_b,
    output logic                     out_illegal
`ifdef ALU_ISSUE_CNT_EN
    ,
    output logic [15:0]              cnt_issued,
    output logic [15:0]              cnt_illegal
`endif
);

    // ALU operation encoding
    localparam logic [OPCODE_LENGTH-1:0] OP_AND     = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] OP_OR      = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD     = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR     = OPCODE_LENGTH'(4'b0011);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLL     = OPCODE_LENGTH'(4'b0100);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRL     = OPCODE_LENGTH'(4'b0101);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB     = OPCODE_LENGTH'(4'b0110);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLT     = OPCODE_LENGTH'(4'b0111);
    localparam logic [OPCODE_LENGTH-1:0] OP_EQ      = OPCODE_LENGTH'(4'b1000);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRA     = OPCODE_LENGTH'(4'b1001);
    localparam logic [OPCODE_LENGTH-1:0] OP_ILLEGAL = OPCODE_LENGTH'(4'b1111);

    // RV32I major opcodes handled by this stage
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    // Buffered entry layout: {op, src_a, src_b, illegal}
    localparam int EW = OPCODE_LENGTH + 2 * DATA_WIDTH + 1;

    logic                     dec_legal;
    logic [OPCODE_LENGTH-1:0] dec_op;
    logic [DATA_WIDTH-1:0]    dec_src_b;
    logic [DATA_WIDTH-1:0]    shamt;

    logic [OPCODE_LENGTH-1:0] ent_op;
    logic [DATA_WIDTH-1:0]    ent_src_a;
    logic [DATA_WIDTH-1:0]    ent_src_b;
    logic                     ent_illegal;
    logic [EW-1:0]            in_entry;

    logic [EW-1:0]            out_entry_reg;
    logic                     out_valid_reg;
    logic [EW-1:0]            skid_entry_reg;
    logic                     skid_valid_reg;

    logic                     accept;
    logic                     consume;
    logic                     out_free;

    // Immediate shifts only use the low five immediate bits, zero-extended
    assign shamt = {{(DATA_WIDTH-5){1'b0}}, in_imm[4:0]};

    // Instruction decode: classify the instruction and pick the ALU op and SrcB
    always_comb begin
        dec_legal = 1'b0;
        dec_op    = OP_ADD;
        dec_src_b = in_rs2;
        case (in_opcode)
            OPC_R, OPC_I: begin
                dec_src_b = (in_opcode == OPC_R) ? in_rs2 : in_imm;
                case (in_funct3)
                    3'b000: begin
                        // ADDI has no SUB variant; funct7 bits there belong to the immediate
                        if (in_opcode == OPC_I || in_funct7 == F7_BASE) begin
                            dec_legal = 1'b1;
                            dec_op    = OP_ADD;
                        end else if (in_funct7 == F7_ALT) begin
                            dec_legal = 1'b1;
                            dec_op    = OP_SUB;
                        end
                    end
                    3'b111: begin
                        dec_legal = 1'b1;
                        dec_op    = OP_AND;
                    end
                    3'b110: begin
                        dec_legal = 1'b1;
                        dec_op    = OP_OR;
                    end
                    3'b100: begin
                        dec_legal = 1'b1;
                        dec_op    = OP_XOR;
                    end
                    3'b010: begin
                        dec_legal = 1'b1;
                        dec_op    = OP_SLT;
                    end
                    3'b001: begin
                        if (in_opcode == OPC_I) begin
                            dec_src_b = shamt;
                        end
                        if (in_funct7 == F7_BASE) begin
                            dec_legal = 1'b1;
                            dec_op    = OP_SLL;
                        end
                    end
                    3'b101: begin
                        if (in_opcode == OPC_I) begin
                            dec_src_b = shamt;
                        end
                        if (in_funct7 == F7_BASE) begin
                            dec_legal = 1'b1;
                            dec_op    = OP_SRL;
                        end else if (in_funct7 == F7_ALT) begin
                            dec_legal = 1'b1;
                            dec_op    = OP_SRA;
                        end
                    end
                    default: begin
                        dec_legal = 1'b0;
                    end
                endcase
            end
            OPC_LOAD, OPC_STORE: begin
                // Address generation: rs1 + offset
                dec_legal = 1'b1;
                dec_op    = OP_ADD;
                dec_src_b = in_imm;
            end
            OPC_BRANCH: begin
                dec_src_b = in_rs2;
                case (in_funct3)
                    3'b000, 3'b001: begin
                        dec_legal = 1'b1;
                        dec_op    = OP_EQ;
                    end
                    3'b100, 3'b101: begin
                        dec_legal = 1'b1;
                        dec_op    = OP_SLT;
                    end
                    default: begin
                        dec_legal = 1'b0;
                    end
                endcase
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase
    end

    // Entry assembly: illegal instructions carry a fixed op code and zeroed sources
    always_comb begin
        ent_op      = OP_ILLEGAL;
        ent_src_a   = '0;
        ent_src_b   = '0;
        ent_illegal = 1'b1;
        if (dec_legal) begin
            ent_op      = dec_op;
            ent_src_a   = in_rs1;
            ent_src_b   = dec_src_b;
            ent_illegal = 1'b0;
        end
    end

    assign in_entry = {ent_op, ent_src_a, ent_src_b, ent_illegal};

    // Handshake qualifiers; in_ready comes straight from the skid flag register
    assign in_ready = !skid_valid_reg;
    assign accept   = in_valid && in_ready && !flush;
    assign consume  = out_valid_reg && out_ready;
    assign out_free = !out_valid_reg || out_ready;

    // Output and skid registers: the skid absorbs one entry while the output stalls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_reg  <= 1'b0;
            out_entry_reg  <= '0;
            skid_valid_reg <= 1'b0;
            skid_entry_reg <= '0;
        end else if (flush) begin
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (out_free) begin
            if (skid_valid_reg) begin
                // Oldest entry lives in the skid; input is blocked while it is full
                out_entry_reg  <= skid_entry_reg;
                out_valid_reg  <= 1'b1;
                skid_valid_reg <= 1'b0;
            end else if (accept) begin
                out_entry_reg <= in_entry;
                out_valid_reg <= 1'b1;
            end else begin
                out_valid_reg <= 1'b0;
            end
        end else if (accept) begin
            skid_entry_reg <= in_entry;
            skid_valid_reg <= 1'b1;
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_op      = out_entry_reg[EW-1 -: OPCODE_LENGTH];
    assign out_src_a   = out_entry_reg[1+DATA_WIDTH +: DATA_WIDTH];
    assign out_src_b   = out_entry_reg[1 +: DATA_WIDTH];
    assign out_illegal = out_entry_reg[0];

`ifdef ALU_ISSUE_CNT_EN
    logic [15:0] cnt_issued_reg;
    logic [15:0] cnt_illegal_reg;

    // Transfer counters: count every downstream handshake, wrapping naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_issued_reg  <= 16'd0;
            cnt_illegal_reg <= 16'd0;
        end else if (consume) begin
            cnt_issued_reg <= cnt_issued_reg + 16'd1;
            if (out_entry_reg[0]) begin
                cnt_illegal_reg <= cnt_illegal_reg + 16'd1;
            end
        end
    end

    assign cnt_issued  = cnt_issued_reg;
    assign cnt_illegal = cnt_illegal_reg;
`else
    // consume only feeds the optional counters
    logic unused_consume;
    assign unused_consume = consume;
`endif

endmodule
